field_set_sequencer: RTL and testbench

//  Parametrised sequencer for entering time or alarm values. It steps a one-hot edit enable across NUM_FIELDS fields
//  (e.g. hour/min/sec, or day/hour/min/sec). Keypad '#' moves to the next field and '*' moves back one field.
//  An inactivity timeout cancels the entry. Sits between the keypad decoder and the per-field digit registers.

---
 rtl/field_set_sequencer_pkg.sv | 21 ++
 rtl/field_set_sequencer_inactivity_timer.sv | 35 +++
 rtl/field_set_sequencer.sv | 99 +++++++++
 tb/tb_field_set_sequencer.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/field_set_sequencer_pkg.sv
// Shared definitions for the field-entry sequencer: state encodings,
// default field counts for clock and alarm entry, and a width helper.
package field_set_sequencer_pkg;

    typedef enum logic [1:0] {
        FS_IDLE  = 2'd0,
        FS_EDIT  = 2'd1,
        FS_DONE  = 2'd2,
        FS_ABORT = 2'd3
    } fs_state_t;

    // hour/min/sec for the clock, day/hour/min/sec for the alarm
    localparam int CLOCK_FIELDS = 3;
    localparam int ALARM_FIELDS = 4;

    // Bits needed to count 0..n-1, never less than one bit
    function automatic int min_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/field_set_sequencer_inactivity_timer.sv
// Down-counting idle timer. load restarts the window, tick consumes one
// cycle of it; expired flags the last cycle of the window. A zero
// TIMEOUT_CYCLES turns the timer off entirely.
module inactivity_timer
    import field_set_sequencer_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic load,
    input  logic tick,
    output logic expired
);

    localparam int TMR_W = min_width(TIMEOUT_CYCLES + 1);
    localparam logic [TMR_W-1:0] RELOAD =
        (TIMEOUT_CYCLES == 0) ? '0 : TMR_W'(TIMEOUT_CYCLES - 1);

    logic [TMR_W-1:0] count;

    // Reload on any key, otherwise count down and park at zero
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (load) begin
            count <= RELOAD;
        end else if (tick && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (TIMEOUT_CYCLES != 0) && (count == '0);

endmodule

// File: rtl/field_set_sequencer.sv
// Steps a one-hot edit enable across NUM_FIELDS fields for time/alarm
// entry: '#' advances or finishes, '*' backs up or cancels, and an idle
// timeout aborts the entry. All outputs are registered.
module field_set_sequencer
    import field_set_sequencer_pkg::*;
#(
    parameter  int NUM_FIELDS     = CLOCK_FIELDS,
    parameter  int TIMEOUT_CYCLES = 1000,
    localparam int IDX_W          = min_width(NUM_FIELDS)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  sharp,
    input  logic                  star,
    input  logic                  activity,
    output logic [NUM_FIELDS-1:0] field_en,
    output logic [IDX_W-1:0]      field_idx,
    output logic                  busy,
    output logic                  complete_setting,
    output logic                  cancelled
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(NUM_FIELDS - 1);

    fs_state_t        state;
    fs_state_t        next_state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] next_idx;
    logic             key;
    logic             timer_load;
    logic             timer_tick;
    logic             expired;

    assign key        = sharp | star | activity;
    assign timer_load = ((state == FS_IDLE) && en) || ((state == FS_EDIT) && key);
    assign timer_tick = (state == FS_EDIT) && !key;

    inactivity_timer #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_timer (
        .clock  (clock),
        .reset  (reset),
        .load   (timer_load),
        .tick   (timer_tick),
        .expired(expired)
    );

    // Next state and field index; a key always beats a same-cycle expiry
    always_comb begin
        next_state = state;
        next_idx   = idx;
        case (state)
            FS_IDLE: begin
                if (en) begin
                    next_state = FS_EDIT;
                end
            end
            FS_EDIT: begin
                if (sharp && !star) begin
                    if (idx == LAST) next_state = FS_DONE;
                    else             next_idx   = idx + 1'b1;
                end else if (star && !sharp) begin
                    if (idx == '0)   next_state = FS_ABORT;
                    else             next_idx   = idx - 1'b1;
                end else if (!key && expired) begin
                    next_state = FS_ABORT;
                end
            end
            default: next_state = FS_IDLE;
        endcase
        if (next_state != FS_EDIT) begin
            next_idx = '0;
        end
    end

    // State, index and Moore outputs registered together
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state            <= FS_IDLE;
            idx              <= '0;
            field_en         <= '0;
            busy             <= 1'b0;
            complete_setting <= 1'b0;
            cancelled        <= 1'b0;
        end else begin
            state            <= next_state;
            idx              <= next_idx;
            field_en         <= (next_state == FS_EDIT) ?
                                (NUM_FIELDS'(1) << next_idx) : '0;
            busy             <= (next_state != FS_IDLE);
            complete_setting <= (next_state == FS_DONE);
            cancelled        <= (next_state == FS_ABORT);
        end
    end

    assign field_idx = idx;

endmodule

// File: tb/tb_field_set_sequencer.sv
// Directed bench for field_set_sequencer with three builds:
// 3 fields / timeout 8, 4 fields / timeout off, 1 field / timeout 5.
module tb_field_set_sequencer;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic       en = 1'b0, sharp = 1'b0, star = 1'b0, activity = 1'b0;
    logic [1:0] sel = 2'd0;
    int         total = 0;
    int         bad   = 0;

    always #5 clock = ~clock;

    // Route stimulus to one build at a time
    logic en_a, sharp_a, star_a, act_a;
    logic en_b, sharp_b, star_b, act_b;
    logic en_c, sharp_c, star_c, act_c;
    assign en_a = en & (sel == 2'd0);  assign sharp_a = sharp & (sel == 2'd0);
    assign star_a = star & (sel == 2'd0); assign act_a = activity & (sel == 2'd0);
    assign en_b = en & (sel == 2'd1);  assign sharp_b = sharp & (sel == 2'd1);
    assign star_b = star & (sel == 2'd1); assign act_b = activity & (sel == 2'd1);
    assign en_c = en & (sel == 2'd2);  assign sharp_c = sharp & (sel == 2'd2);
    assign star_c = star & (sel == 2'd2); assign act_c = activity & (sel == 2'd2);

    logic [2:0] fe_a; logic [1:0] idx_a; logic busy_a, comp_a, canc_a;
    logic [3:0] fe_b; logic [1:0] idx_b; logic busy_b, comp_b, canc_b;
    logic [0:0] fe_c; logic [0:0] idx_c; logic busy_c, comp_c, canc_c;

    field_set_sequencer #(.NUM_FIELDS(3), .TIMEOUT_CYCLES(8)) dut_a (
        .clock(clock), .reset(reset), .en(en_a), .sharp(sharp_a), .star(star_a),
        .activity(act_a), .field_en(fe_a), .field_idx(idx_a), .busy(busy_a),
        .complete_setting(comp_a), .cancelled(canc_a));

    field_set_sequencer #(.NUM_FIELDS(4), .TIMEOUT_CYCLES(0)) dut_b (
        .clock(clock), .reset(reset), .en(en_b), .sharp(sharp_b), .star(star_b),
        .activity(act_b), .field_en(fe_b), .field_idx(idx_b), .busy(busy_b),
        .complete_setting(comp_b), .cancelled(canc_b));

    field_set_sequencer #(.NUM_FIELDS(1), .TIMEOUT_CYCLES(5)) dut_c (
        .clock(clock), .reset(reset), .en(en_c), .sharp(sharp_c), .star(star_c),
        .activity(act_c), .field_en(fe_c), .field_idx(idx_c), .busy(busy_c),
        .complete_setting(comp_c), .cancelled(canc_c));

    // Packed views: {field_en, field_idx, busy, complete_setting, cancelled}
    logic [7:0] obs_a;
    logic [8:0] obs_b;
    logic [4:0] obs_c;
    assign obs_a = {fe_a, idx_a, busy_a, comp_a, canc_a};
    assign obs_b = {fe_b, idx_b, busy_b, comp_b, canc_b};
    assign obs_c = {fe_c, idx_c, busy_c, comp_c, canc_c};

    localparam logic [7:0] A_IDLE = 8'b000_00_0_0_0;
    localparam logic [7:0] A_F0   = 8'b001_00_1_0_0;
    localparam logic [7:0] A_F1   = 8'b010_01_1_0_0;
    localparam logic [7:0] A_F2   = 8'b100_10_1_0_0;
    localparam logic [7:0] A_DONE = 8'b000_00_1_1_0;
    localparam logic [7:0] A_ABRT = 8'b000_00_1_0_1;

    localparam logic [8:0] B_IDLE = 9'b0000_00_0_0_0;
    localparam logic [8:0] B_F0   = 9'b0001_00_1_0_0;
    localparam logic [8:0] B_F1   = 9'b0010_01_1_0_0;
    localparam logic [8:0] B_F2   = 9'b0100_10_1_0_0;
    localparam logic [8:0] B_F3   = 9'b1000_11_1_0_0;
    localparam logic [8:0] B_DONE = 9'b0000_00_1_1_0;

    localparam logic [4:0] C_IDLE = 5'b0_0_0_0_0;
    localparam logic [4:0] C_F0   = 5'b1_0_1_0_0;
    localparam logic [4:0] C_DONE = 5'b0_0_1_1_0;
    localparam logic [4:0] C_ABRT = 5'b0_0_1_0_1;

    task automatic check(input string tag, input logic [15:0] observed,
                         input logic [15:0] expected);
        total++;
        assert (observed === expected)
        else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, observed, expected);
        end
    endtask

    // One clock with the given key pulses, outputs settle 1 unit later
    task automatic step(input logic e, input logic sh, input logic st, input logic ac);
        en = e; sharp = sh; star = st; activity = ac;
        @(posedge clock);
        #1;
        en = 1'b0; sharp = 1'b0; star = 1'b0; activity = 1'b0;
    endtask

    // field_en must never show more than one hot bit
    always @(negedge clock) begin
        total++;
        assert ($onehot0(fe_a) && $onehot0(fe_b) && $onehot0(fe_c))
        else begin
            bad++;
            $error("FAIL onehot observed=%b/%b/%b expected=onehot0", fe_a, fe_b, fe_c);
        end
    end

    initial begin
        // Reset held
        #23;
        check("reset_a", 16'(obs_a), 16'(A_IDLE));
        check("reset_b", 16'(obs_b), 16'(B_IDLE));
        check("reset_c", 16'(obs_c), 16'(C_IDLE));
        #4 reset = 1'b1;
        @(posedge clock); #1;
        check("post_reset_a", 16'(obs_a), 16'(A_IDLE));

        // Forward walk to completion; en during DONE dropped
        sel = 2'd0;
        step(1, 0, 0, 0); check("fwd_f0", 16'(obs_a), 16'(A_F0));
        step(0, 1, 0, 0); check("fwd_f1", 16'(obs_a), 16'(A_F1));
        step(0, 1, 0, 0); check("fwd_f2", 16'(obs_a), 16'(A_F2));
        step(0, 1, 0, 0); check("fwd_done", 16'(obs_a), 16'(A_DONE));
        step(1, 0, 0, 0); check("fwd_idle", 16'(obs_a), 16'(A_IDLE));
        step(0, 1, 1, 1); check("idle_keys_ignored", 16'(obs_a), 16'(A_IDLE));

        // Backward walk to cancel; en during ABORT dropped
        step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        check("bk_f2", 16'(obs_a), 16'(A_F2));
        step(0, 0, 1, 0); check("bk_f1", 16'(obs_a), 16'(A_F1));
        step(0, 0, 1, 0); check("bk_f0", 16'(obs_a), 16'(A_F0));
        step(0, 0, 1, 0); check("bk_abort", 16'(obs_a), 16'(A_ABRT));
        step(1, 0, 0, 0); check("bk_idle", 16'(obs_a), 16'(A_IDLE));

        // Timeout with no keys: 8 cycles in field 0, then cancel
        step(1, 0, 0, 0); check("to_start", 16'(obs_a), 16'(A_F0));
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0); check("to_hold", 16'(obs_a), 16'(A_F0));
        end
        step(0, 0, 0, 0); check("to_abort", 16'(obs_a), 16'(A_ABRT));
        step(0, 0, 0, 0); check("to_idle", 16'(obs_a), 16'(A_IDLE));

        // Activity on cycle 6 pushes the abort 8 cycles past it
        step(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 0, 0, 0);
        step(0, 0, 0, 1); check("act_hold", 16'(obs_a), 16'(A_F0));
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0); check("act_wait", 16'(obs_a), 16'(A_F0));
        end
        step(0, 0, 0, 0); check("act_abort", 16'(obs_a), 16'(A_ABRT));
        step(0, 0, 0, 0);

        // sharp+star together at idx 1: no move, timer reloaded
        step(1, 0, 0, 0); step(0, 1, 0, 0);
        for (int i = 0; i < 5; i++) step(0, 0, 0, 0);
        step(0, 1, 1, 0); check("both_keys", 16'(obs_a), 16'(A_F1));
        for (int i = 1; i < 8; i++) begin
            step(0, 0, 0, 0); check("both_reload", 16'(obs_a), 16'(A_F1));
        end
        step(0, 0, 0, 0); check("both_abort", 16'(obs_a), 16'(A_ABRT));
        step(0, 0, 0, 0);

        // Final sharp on the exact expiry cycle completes
        step(1, 0, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        for (int i = 1; i < 8; i++) step(0, 0, 0, 0);
        check("exp_last", 16'(obs_a), 16'(A_F2));
        step(0, 1, 0, 0); check("exp_done", 16'(obs_a), 16'(A_DONE));
        step(0, 0, 0, 0);

        // Asynchronous reset mid-entry at idx 1
        step(1, 0, 0, 0); step(0, 1, 0, 0);
        #3 reset = 1'b0;
        #1 check("arst_now", 16'(obs_a), 16'(A_IDLE));
        #2 reset = 1'b1;
        @(posedge clock); #1;
        check("arst_after", 16'(obs_a), 16'(A_IDLE));
        step(1, 0, 0, 0); check("arst_restart", 16'(obs_a), 16'(A_F0));
        step(0, 0, 1, 0); check("arst_cancel", 16'(obs_a), 16'(A_ABRT));
        step(0, 0, 0, 0);

        // Four fields, timeout disabled
        sel = 2'd1;
        step(1, 0, 0, 0); check("b_f0", 16'(obs_b), 16'(B_F0));
        step(0, 1, 0, 0); check("b_f1", 16'(obs_b), 16'(B_F1));
        step(0, 1, 0, 0); check("b_f2", 16'(obs_b), 16'(B_F2));
        step(0, 1, 0, 0); check("b_f3", 16'(obs_b), 16'(B_F3));
        step(0, 0, 1, 0); check("b_back2", 16'(obs_b), 16'(B_F2));
        step(0, 0, 1, 0); check("b_back1", 16'(obs_b), 16'(B_F1));
        step(0, 0, 1, 0); check("b_back0", 16'(obs_b), 16'(B_F0));
        step(1, 0, 0, 0); check("b_en_in_edit", 16'(obs_b), 16'(B_F0));
        for (int i = 0; i < 20; i++) step(0, 0, 0, 0);
        check("b_no_timeout", 16'(obs_b), 16'(B_F0));
        step(0, 1, 0, 0); step(0, 1, 0, 0); step(0, 1, 0, 0);
        check("b_f3_again", 16'(obs_b), 16'(B_F3));
        step(0, 1, 0, 0); check("b_done", 16'(obs_b), 16'(B_DONE));
        step(1, 0, 0, 0); check("b_idle", 16'(obs_b), 16'(B_IDLE));

        // Single field, timeout 5
        sel = 2'd2;
        step(1, 0, 0, 0); check("c_f0", 16'(obs_c), 16'(C_F0));
        step(0, 1, 0, 0); check("c_done", 16'(obs_c), 16'(C_DONE));
        step(0, 0, 0, 0); check("c_idle", 16'(obs_c), 16'(C_IDLE));
        step(1, 0, 0, 0);
        step(0, 0, 1, 0); check("c_abort", 16'(obs_c), 16'(C_ABRT));
        step(0, 0, 0, 0); check("c_idle2", 16'(obs_c), 16'(C_IDLE));
        step(1, 0, 0, 0);
        for (int i = 1; i < 5; i++) begin
            step(0, 0, 0, 0); check("c_to_hold", 16'(obs_c), 16'(C_F0));
        end
        step(0, 0, 0, 0); check("c_to_abort", 16'(obs_c), 16'(C_ABRT));
        step(0, 0, 0, 0); check("c_to_idle", 16'(obs_c), 16'(C_IDLE));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
